// File: rtl/parking_exit_occupancy.sv
// parking_exit_occupancy
//   Exit lane controller for the parking lot plus the shared occupancy register.
//   Follows a car through the exit lane using an inner/outer sensor pair, drives
//   the exit gate, and keeps the count of cars inside. The count goes up on
//   entry pulses from the entry side and down on completed exits. Full is fed
//   back to the entry controller.
//
//   Ports
//     CLK        in   1      system clock, rising edge
//     reset      in   1      asynchronous, active-high
//     EntradaOK  in   1      one-cycle pulse, one car completed entry
//     SSI        in   1      exit inner sensor (lot side), 1 = occupied
//     SSE        in   1      exit outer sensor (street side), 1 = occupied
//     Cancela    out  1      exit gate open
//     Alarme     out  1      wrong-way or lane timeout
//     SaidaOK    out  1      one-cycle pulse, one car completed exit
//     Full       out  1      Ocupacao == CAPACITY
//     Ocupacao   out  CNT_W  cars currently inside
//     Vagas      out  CNT_W  free spaces
//
//   state     | meaning
//   LIVRE     | lane empty, gate closed
//   INTERNO   | car on inner sensor only, gate open
//   AMBOS     | car covering both sensors, gate open
//   EXTERNO   | car on outer sensor only, gate open
//   CONTRAMAO | car entered from street side (wrong way), alarm
//   ABORTADO  | lane timeout, alarm until lane clears

module parking_exit_occupancy #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 50,
    parameter int TMR_W    = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             EntradaOK,
    input  logic             SSI,
    input  logic             SSE,
    output logic             Cancela,
    output logic             Alarme,
    output logic             SaidaOK,
    output logic             Full,
    output logic [CNT_W-1:0] Ocupacao,
    output logic [CNT_W-1:0] Vagas
);

    typedef enum logic [2:0] {
        LIVRE     = 3'd0,
        INTERNO   = 3'd1,
        AMBOS     = 3'd2,
        EXTERNO   = 3'd3,
        CONTRAMAO = 3'd4,
        ABORTADO  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic             in_lane;
    logic             exit_evt;
    logic             cancela_nxt, alarme_nxt;
    logic [CNT_W-1:0] ocup_nxt;

    assign in_lane = (state == INTERNO) || (state == AMBOS) || (state == EXTERNO);

    // A completed exit is the EXTERNO -> LIVRE edge; the timeout can never
    // override it because the abort only applies when the lane is not clearing.
    assign exit_evt = (state == EXTERNO) && !SSI && !SSE;

    // State register, registered Moore outputs and exit pulse
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= LIVRE;
            Cancela <= 1'b0;
            Alarme  <= 1'b0;
            SaidaOK <= 1'b0;
        end else begin
            state   <= state_nxt;
            Cancela <= cancela_nxt;
            Alarme  <= alarme_nxt;
            SaidaOK <= exit_evt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = LIVRE;
        case (state)
            LIVRE: begin
                if (SSE)      state_nxt = CONTRAMAO;
                else if (SSI) state_nxt = INTERNO;
                else          state_nxt = LIVRE;
            end
            INTERNO: begin
                if (SSI && SSE)       state_nxt = AMBOS;
                else if (SSE)         state_nxt = EXTERNO;
                else if (SSI)         state_nxt = INTERNO;
                else                  state_nxt = LIVRE;
            end
            AMBOS: begin
                if (SSI && SSE)       state_nxt = AMBOS;
                else if (SSE)         state_nxt = EXTERNO;
                else if (SSI)         state_nxt = INTERNO;
                else                  state_nxt = LIVRE;
            end
            EXTERNO: begin
                if (SSI)              state_nxt = AMBOS;
                else if (SSE)         state_nxt = EXTERNO;
                else                  state_nxt = LIVRE;
            end
            CONTRAMAO: begin
                if (!SSI && !SSE)     state_nxt = LIVRE;
                else                  state_nxt = CONTRAMAO;
            end
            ABORTADO: begin
                if (!SSI && !SSE)     state_nxt = LIVRE;
                else                  state_nxt = ABORTADO;
            end
            default:                  state_nxt = LIVRE;
        endcase

        // Lane timeout takes priority over any move that keeps the car in the lane
        if (in_lane && (timer == TMR_END) && (state_nxt != LIVRE))
            state_nxt = ABORTADO;
    end

    // Output decode on the next state so the outputs register alongside it
    always_comb begin
        cancela_nxt = 1'b0;
        alarme_nxt  = 1'b0;
        case (state_nxt)
            INTERNO, AMBOS, EXTERNO: cancela_nxt = 1'b1;
            CONTRAMAO, ABORTADO:     alarme_nxt  = 1'b1;
            default: begin
                cancela_nxt = 1'b0;
                alarme_nxt  = 1'b0;
            end
        endcase
    end

    // Lane timer: counts cycles spent in the lane, not restarted on lane moves
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)        timer <= '0;
        else if (in_lane) timer <= timer + 1'b1;
        else              timer <= '0;
    end

    // Occupancy: simultaneous entry and exit cancel, both directions saturate
    always_comb begin
        ocup_nxt = Ocupacao;
        if (EntradaOK && !exit_evt) begin
            if (Ocupacao != CAP_C) ocup_nxt = Ocupacao + 1'b1;
        end else if (exit_evt && !EntradaOK) begin
            if (Ocupacao != '0)    ocup_nxt = Ocupacao - 1'b1;
        end
    end

    // Full and Vagas come from the same next value so they never lag Ocupacao
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            Ocupacao <= '0;
            Vagas    <= CAP_C;
            Full     <= 1'b0;
        end else begin
            Ocupacao <= ocup_nxt;
            Vagas    <= CAP_C - ocup_nxt;
            Full     <= (ocup_nxt == CAP_C);
        end
    end

endmodule

// File: tb/tb_parking_exit_occupancy.sv
module tb_parking_exit_occupancy;

    logic       CLK = 1'b0;
    logic       reset;
    logic       EntradaOK, SSI, SSE;
    logic       Cancela, Alarme, SaidaOK, Full;
    logic [3:0] Ocupacao, Vagas;

    int errors = 0;
    int checks = 0;

    parking_exit_occupancy #(
        .CAPACITY(8), .CNT_W(4), .TIMEOUT(50), .TMR_W(8)
    ) dut (
        .CLK(CLK), .reset(reset), .EntradaOK(EntradaOK), .SSI(SSI), .SSE(SSE),
        .Cancela(Cancela), .Alarme(Alarme), .SaidaOK(SaidaOK), .Full(Full),
        .Ocupacao(Ocupacao), .Vagas(Vagas)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one clock edge and settle just after it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sens(input logic i, input logic e);
        SSI = i;
        SSE = e;
    endtask

    task automatic entry_pulse();
        EntradaOK = 1'b1;
        step();
        EntradaOK = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; EntradaOK = 1'b0; SSI = 1'b0; SSE = 1'b0;

        // 1: reset values and filling the lot
        step(); step();
        check("rst_cancela", Cancela, 0);
        check("rst_alarme", Alarme, 0);
        check("rst_saidaok", SaidaOK, 0);
        check("rst_full", Full, 0);
        check("rst_ocup", Ocupacao, 0);
        check("rst_vagas", Vagas, 8);
        reset = 1'b0;
        for (int k = 0; k < 7; k++) entry_pulse();
        check("fill7_ocup", Ocupacao, 7);
        check("fill7_full", Full, 0);
        check("fill7_vagas", Vagas, 1);
        entry_pulse();
        check("fill8_ocup", Ocupacao, 8);
        check("fill8_full", Full, 1);
        check("fill8_vagas", Vagas, 0);
        entry_pulse();
        check("sat_ocup", Ocupacao, 8);
        check("sat_full", Full, 1);

        // 2: normal exit with Ocupacao = 3
        do_reset();
        for (int k = 0; k < 3; k++) entry_pulse();
        check("pre_exit_ocup", Ocupacao, 3);
        sens(1, 0); step();
        check("interno_cancela", Cancela, 1);
        sens(1, 1); step();
        check("ambos_cancela", Cancela, 1);
        check("ambos_saidaok", SaidaOK, 0);
        sens(0, 1); step();
        check("externo_cancela", Cancela, 1);
        sens(0, 0); step();
        check("exit_cancela", Cancela, 0);
        check("exit_saidaok", SaidaOK, 1);
        check("exit_ocup", Ocupacao, 2);
        check("exit_vagas", Vagas, 6);
        step();
        check("saidaok_width", SaidaOK, 0);

        // 3: wrong way
        sens(0, 1); step();
        check("cm_alarme", Alarme, 1);
        check("cm_cancela", Cancela, 0);
        sens(1, 1); step();
        check("cm_hold_alarme", Alarme, 1);
        sens(0, 0); step();
        check("cm_clear_alarme", Alarme, 0);
        check("cm_ocup", Ocupacao, 2);
        check("cm_saidaok", SaidaOK, 0);

        // 4: lane timeout; INTERNO entered on first edge, abort on the 51st
        sens(1, 0);
        for (int k = 0; k < 50; k++) step();
        check("to_before_cancela", Cancela, 1);
        check("to_before_alarme", Alarme, 0);
        step();
        check("to_alarme", Alarme, 1);
        check("to_cancela", Cancela, 0);
        step();
        check("to_hold_alarme", Alarme, 1);
        sens(0, 0); step();
        check("to_clear_alarme", Alarme, 0);
        check("to_saidaok", SaidaOK, 0);
        check("to_ocup", Ocupacao, 2);

        // 5: full lot, entry on the same edge as the exit
        for (int k = 0; k < 6; k++) entry_pulse();
        check("full_pre", Full, 1);
        sens(1, 0); step();
        sens(0, 1); step();
        check("full_externo_cancela", Cancela, 1);
        sens(0, 0); EntradaOK = 1'b1; step();
        EntradaOK = 1'b0;
        check("both_saidaok", SaidaOK, 1);
        check("both_ocup", Ocupacao, 8);
        check("both_full", Full, 1);
        check("both_vagas", Vagas, 0);
        // plain exit from full
        sens(1, 0); step();
        sens(0, 1); step();
        sens(0, 0); step();
        check("dec_ocup", Ocupacao, 7);
        check("dec_full", Full, 0);
        check("dec_vagas", Vagas, 1);

        // 6: asynchronous reset while in AMBOS
        sens(1, 0); step();
        sens(1, 1); step();
        check("pre_rst_cancela", Cancela, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_cancela", Cancela, 0);
        check("arst_alarme", Alarme, 0);
        check("arst_ocup", Ocupacao, 0);
        check("arst_vagas", Vagas, 8);
        check("arst_full", Full, 0);
        sens(0, 0);
        step();
        reset = 1'b0;

        // exit at zero occupancy still pulses but count stays 0
        sens(1, 0); step();
        sens(0, 1); step();
        sens(0, 0); step();
        check("zero_saidaok", SaidaOK, 1);
        check("zero_ocup", Ocupacao, 0);
        check("zero_vagas", Vagas, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
